// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: tracks slot occupancy, operand readiness and age,
// and offers the oldest ready slot to the functional unit over a valid/ready handshake.
module rs_issue_scheduler #(
  parameter int NUM_RS_ENTRIES = 8,
  parameter int TYPE           = 0,
  localparam int IDX_W         = $clog2(NUM_RS_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      alloc_valid_0,
  input  logic [IDX_W-1:0]          alloc_slot_0,
  input  logic                      alloc_rdy_0,
  input  logic                      alloc_valid_1,
  input  logic [IDX_W-1:0]          alloc_slot_1,
  input  logic                      alloc_rdy_1,
  input  logic [NUM_RS_ENTRIES-1:0] ready_set,
  output logic                      issue_valid,
  output logic [IDX_W-1:0]          issue_slot,
  input  logic                      issue_ready,
  output logic                      return_slot_valid,
  output logic [IDX_W-1:0]          return_slot,
  output logic [IDX_W:0]            occupancy,
  output logic                      err_alloc
);

  localparam int N  = NUM_RS_ENTRIES;
  localparam int CW = IDX_W + 2;

  if (TYPE < 0 || TYPE > 2) begin : g_bad_type
    $error("rs_issue_scheduler: TYPE must be 0, 1 or 2");
  end
  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_size
    $error("rs_issue_scheduler: NUM_RS_ENTRIES must be a power of two >= 2");
  end

  logic [N-1:0]     occ_q, rdy_q, occ_d, rdy_d, occ_base, cand;
  logic [N-1:0]     old_q [N];
  logic [N-1:0]     old_d [N];
  logic             lock_v_q;
  logic [IDX_W-1:0] lock_slot_q;
  logic             ret_v_q;
  logic [IDX_W-1:0] ret_slot_q;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] oldest;
  logic             found, blocked, fire;
  logic [CW-1:0]    cnt_sum;

  // Oldest ready slot: the candidate that no other candidate is older than.
  always_comb begin
    cand    = occ_q & rdy_q;
    oldest  = '0;
    found   = 1'b0;
    blocked = 1'b0;
    for (int i = 0; i < N; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (cand[j] && old_q[j][i]) blocked = 1'b1;
      end
      if (cand[i] && !blocked && !found) begin
        oldest = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

  assign issue_valid       = lock_v_q | (|cand);
  assign issue_slot        = lock_v_q ? lock_slot_q : oldest;
  assign fire              = issue_valid & issue_ready;
  assign return_slot_valid = ret_v_q;
  assign return_slot       = ret_slot_q;
  assign occupancy         = cnt_q;
  assign err_alloc         = err_q;

  always_comb begin
    occ_d = occ_q;
    rdy_d = rdy_q | (ready_set & occ_q);
    for (int i = 0; i < N; i++) old_d[i] = old_q[i];
    if (fire) begin
      occ_d[issue_slot] = 1'b0;
      rdy_d[issue_slot] = 1'b0;
    end
    occ_base = occ_d;
    // Age columns: every slot still resident is older than the new entry; lane 0 beats lane 1.
    if (alloc_valid_0) begin
      for (int j = 0; j < N; j++) begin
        if (occ_base[j]) old_d[j][alloc_slot_0] = 1'b1;
      end
      occ_d[alloc_slot_0] = 1'b1;
      rdy_d[alloc_slot_0] = alloc_rdy_0 | ready_set[alloc_slot_0];
    end
    if (alloc_valid_1) begin
      for (int j = 0; j < N; j++) begin
        if (occ_base[j]) old_d[j][alloc_slot_1] = 1'b1;
      end
      occ_d[alloc_slot_1] = 1'b1;
      rdy_d[alloc_slot_1] = alloc_rdy_1 | ready_set[alloc_slot_1];
    end
    if (alloc_valid_0) old_d[alloc_slot_0] = '0;
    if (alloc_valid_1) old_d[alloc_slot_1] = '0;
    if (alloc_valid_0 && alloc_valid_1 && alloc_slot_0 != alloc_slot_1)
      old_d[alloc_slot_0][alloc_slot_1] = 1'b1;

    cnt_sum = CW'(cnt_q) + CW'(alloc_valid_0) + CW'(alloc_valid_1);
    if (fire) cnt_sum = (cnt_sum != '0) ? cnt_sum - CW'(1) : '0;
    cnt_d = (cnt_sum > CW'(N)) ? (IDX_W+1)'(N) : cnt_sum[IDX_W:0];

    err_d = err_q
          | (alloc_valid_0 & occ_q[alloc_slot_0])
          | (alloc_valid_1 & occ_q[alloc_slot_1])
          | (alloc_valid_0 & alloc_valid_1 & (alloc_slot_0 == alloc_slot_1))
          | (fire & alloc_valid_0 & (alloc_slot_0 == issue_slot))
          | (fire & alloc_valid_1 & (alloc_slot_1 == issue_slot));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= '0;
      rdy_q       <= '0;
      for (int i = 0; i < N; i++) old_q[i] <= '0;
      lock_v_q    <= 1'b0;
      lock_slot_q <= '0;
      ret_v_q     <= 1'b0;
      ret_slot_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else if (flush) begin
      occ_q    <= '0;
      rdy_q    <= '0;
      for (int i = 0; i < N; i++) old_q[i] <= '0;
      lock_v_q <= 1'b0;
      ret_v_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q <= occ_d;
      rdy_q <= rdy_d;
      for (int i = 0; i < N; i++) old_q[i] <= old_d[i];
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ret_v_q <= fire;
      if (fire) ret_slot_q <= issue_slot;
      // Hold the offered slot steady while the FU stalls.
      if (fire) begin
        lock_v_q <= 1'b0;
      end else if (issue_valid) begin
        lock_v_q    <= 1'b1;
        lock_slot_q <= issue_slot;
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with hand-computed expectations.
module tb_rs_issue_scheduler;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         alloc_valid_0 = 1'b0, alloc_valid_1 = 1'b0;
  logic [W-1:0] alloc_slot_0 = '0, alloc_slot_1 = '0;
  logic         alloc_rdy_0 = 1'b0, alloc_rdy_1 = 1'b0;
  logic [N-1:0] ready_set = '0;
  logic         issue_valid;
  logic [W-1:0] issue_slot;
  logic         issue_ready = 1'b0;
  logic         return_slot_valid;
  logic [W-1:0] return_slot;
  logic [W:0]   occupancy;
  logic         err_alloc;

  int checks = 0;
  int errors = 0;

  rs_issue_scheduler #(.NUM_RS_ENTRIES(N), .TYPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid_0(alloc_valid_0), .alloc_slot_0(alloc_slot_0), .alloc_rdy_0(alloc_rdy_0),
    .alloc_valid_1(alloc_valid_1), .alloc_slot_1(alloc_slot_1), .alloc_rdy_1(alloc_rdy_1),
    .ready_set(ready_set), .issue_valid(issue_valid), .issue_slot(issue_slot),
    .issue_ready(issue_ready), .return_slot_valid(return_slot_valid),
    .return_slot(return_slot), .occupancy(occupancy), .err_alloc(err_alloc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid_0 = 1'b0; alloc_valid_1 = 1'b0;
    alloc_rdy_0   = 1'b0; alloc_rdy_1   = 1'b0;
    ready_set     = '0;   flush         = 1'b0;
  endtask

  task automatic alloc0(input int s, input bit r);
    alloc_valid_0 = 1'b1; alloc_slot_0 = W'(s); alloc_rdy_0 = r;
  endtask

  task automatic alloc1(input int s, input bit r);
    alloc_valid_1 = 1'b1; alloc_slot_1 = W'(s); alloc_rdy_1 = r;
  endtask

  task automatic do_reset();
    idle();
    issue_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // reset with random inputs
    alloc_valid_0 = 1'($urandom); alloc_slot_0 = W'($urandom);
    alloc_valid_1 = 1'($urandom); alloc_slot_1 = W'($urandom);
    ready_set = N'($urandom); issue_ready = 1'($urandom); flush = 1'($urandom);
    tick(); tick();
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_slot", issue_slot, 0);
    chk("rst_ret_valid", return_slot_valid, 0);
    chk("rst_ret_slot", return_slot, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_err", err_alloc, 0);
    idle(); issue_ready = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_idle", issue_valid, 0);

    // single alloc and issue
    issue_ready = 1'b1;
    alloc0(3, 1'b1);
    tick(); idle();
    chk("single_valid", issue_valid, 1);
    chk("single_slot", issue_slot, 3);
    chk("single_occ", occupancy, 1);
    tick();
    chk("single_ret_valid", return_slot_valid, 1);
    chk("single_ret_slot", return_slot, 3);
    chk("single_occ_zero", occupancy, 0);
    chk("single_drained", issue_valid, 0);
    tick();
    chk("single_ret_pulse", return_slot_valid, 0);

    // age order
    alloc0(5, 1'b0); tick(); idle();
    alloc0(2, 1'b0); tick(); idle();
    chk("age_not_ready", issue_valid, 0);
    ready_set = 8'b0010_0100; tick(); idle();
    chk("age_first", issue_slot, 5);
    chk("age_first_v", issue_valid, 1);
    tick();
    chk("age_second", issue_slot, 2);
    chk("age_ret5", return_slot, 5);
    tick();
    chk("age_ret2", return_slot, 2);
    chk("age_empty", issue_valid, 0);
    alloc0(6, 1'b1); alloc1(1, 1'b1); tick(); idle();
    chk("dual_occ", occupancy, 2);
    chk("dual_first", issue_slot, 6);
    tick();
    chk("dual_second", issue_slot, 1);
    tick();
    chk("dual_ret1", return_slot, 1);
    chk("dual_empty", issue_valid, 0);
    chk("dual_err", err_alloc, 0);

    // backpressure: offered slot stays locked
    issue_ready = 1'b0;
    alloc0(0, 1'b0); tick(); idle();
    alloc0(4, 1'b1); tick(); idle();
    chk("bp_offer", issue_slot, 4);
    tick();
    ready_set = 8'b0000_0001; tick(); idle();
    chk("bp_hold1", issue_slot, 4);
    tick();
    chk("bp_hold2", issue_slot, 4);
    chk("bp_hold_v", issue_valid, 1);
    issue_ready = 1'b1; tick();
    chk("bp_next", issue_slot, 0);
    chk("bp_ret4", return_slot, 4);
    tick();
    chk("bp_ret0", return_slot, 0);
    chk("bp_empty", issue_valid, 0);
    issue_ready = 1'b0;

    // full and error
    for (int k = 0; k < 4; k++) begin
      alloc0(2*k, 1'b0); alloc1(2*k+1, 1'b0); tick(); idle();
    end
    chk("full_occ", occupancy, 8);
    chk("full_no_err", err_alloc, 0);
    alloc0(2, 1'b0); tick(); idle();
    chk("full_err", err_alloc, 1);
    chk("full_occ_sat", occupancy, 8);
    tick(); tick();
    chk("full_err_sticky", err_alloc, 1);
    do_reset();
    chk("err_cleared", err_alloc, 0);
    alloc0(5, 1'b0); alloc1(5, 1'b0); tick(); idle();
    chk("same_slot_err", err_alloc, 1);

    // flush with lock and concurrent fire
    do_reset();
    alloc0(0, 1'b1); alloc1(1, 1'b1); tick(); idle();
    alloc0(2, 1'b1); alloc1(3, 1'b1); tick(); idle();
    alloc0(4, 1'b1); tick(); idle();
    chk("fl_occ5", occupancy, 5);
    chk("fl_locked", issue_slot, 0);
    flush = 1'b1; issue_ready = 1'b1; tick(); idle();
    chk("fl_valid", issue_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_ret", return_slot_valid, 0);
    chk("fl_err_held", err_alloc, 0);
    alloc0(0, 1'b1); tick(); idle();
    chk("fl_new_issue", issue_valid, 1);
    chk("fl_new_slot", issue_slot, 0);
    tick();
    chk("fl_new_ret", return_slot_valid, 1);
    chk("fl_new_ret_slot", return_slot, 0);

    // async reset mid-handshake
    issue_ready = 1'b0;
    alloc0(7, 1'b1); tick(); idle();
    chk("ar_offer", issue_valid, 1);
    #2 rst_n = 1'b0; #1;
    chk("ar_drop", issue_valid, 0);
    chk("ar_occ", occupancy, 0);
    #5 rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
